// File: rtl/arith_pkg.sv
// Shared encodings for the sequential arithmetic unit: operation codes and FSM states.
package arith_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_DIV  = 2'b10,
        S_DONE = 2'b11
    } state_e;

endpackage

// File: rtl/seq_divider.sv
// Unsigned restoring divider: loads on start, retires one quotient bit per cycle (MSB first),
// raises done after WIDTH iterations and holds it until the next start.
module seq_divider #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    logic             busy;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] quo_p0;
    logic [WIDTH-1:0] rem_p0;
    logic [WIDTH-1:0] dvs_p0;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    // The partial remainder is always below the divisor, so WIDTH+1 bits keep the trial sign unambiguous.
    always_comb begin
        shifted = {rem_p0, quo_p0[WIDTH-1]};
        trial   = shifted - {1'b0, dvs_p0};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy <= 1'b0;
            cnt  <= '0;
            done <= 1'b0;
        end else if (start) begin
            busy <= 1'b1;
            cnt  <= '0;
            done <= 1'b0;
        end else if (busy) begin
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(WIDTH - 1)) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (start) begin
            quo_p0 <= dividend;
            rem_p0 <= '0;
            dvs_p0 <= divisor;
        end else if (busy) begin
            if (!trial[WIDTH]) begin
                rem_p0 <= trial[WIDTH-1:0];
                quo_p0 <= {quo_p0[WIDTH-2:0], 1'b1};
            end else begin
                rem_p0 <= shifted[WIDTH-1:0];
                quo_p0 <= {quo_p0[WIDTH-2:0], 1'b0};
            end
        end
    end

    assign quotient  = quo_p0;
    assign remainder = rem_p0;

endmodule

// File: rtl/arith_unit_seq.sv
// Clocked add/sub/mul/div unit with valid/ready handshakes on operand and result sides.
// Add/sub/mul resolve in EXEC; nonzero divides go through the iterative divider on magnitudes.
module arith_unit_seq
    import arith_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [1:0]       i_op,
    input  logic             i_signed,
    input  logic [WIDTH-1:0] i_value_a,
    input  logic [WIDTH-1:0] i_value_b,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_result,
    output logic [WIDTH-1:0] o_result_hi,
    output logic             o_overflow,
    output logic             o_div_zero
);

    function automatic logic add_ovf(input logic sgn, input logic [WIDTH-1:0] a,
                                     input logic [WIDTH-1:0] b, input logic [WIDTH:0] s);
        return sgn ? ((a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1])) : s[WIDTH];
    endfunction

    function automatic logic sub_ovf(input logic sgn, input logic [WIDTH-1:0] a,
                                     input logic [WIDTH-1:0] b, input logic [WIDTH:0] d);
        return sgn ? ((a[WIDTH-1] != b[WIDTH-1]) && (d[WIDTH-1] != a[WIDTH-1])) : d[WIDTH];
    endfunction

    function automatic logic mul_ovf(input logic sgn, input logic [2*WIDTH-1:0] p);
        return sgn ? (p[2*WIDTH-1:WIDTH] != {WIDTH{p[WIDTH-1]}}) : (p[2*WIDTH-1:WIDTH] != '0);
    endfunction

    function automatic logic [WIDTH-1:0] cond_neg(input logic neg, input logic [WIDTH-1:0] v);
        return neg ? (~v + 1'b1) : v;
    endfunction

    state_e             state;
    logic               accept;
    logic               div_start;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH-1:0]   a_p0;
    logic [WIDTH-1:0]   b_p0;
    op_e                op_p0;
    logic               sgn_p0;
    logic               neg_q_p0;
    logic               neg_r_p0;
    logic               ovf_div_p0;
    logic [WIDTH:0]     sum_p1;
    logic [WIDTH:0]     diff_p1;
    logic [2*WIDTH-1:0] prod_u_p1;
    logic [2*WIDTH-1:0] prod_s_p1;
    logic [2*WIDTH-1:0] prod_p1;
    logic               div_done;
    logic [WIDTH-1:0]   div_quo;
    logic [WIDTH-1:0]   div_rem;

    assign o_ready   = (state == S_IDLE);
    assign accept    = i_valid && o_ready;
    assign div_start = accept && (i_op == OP_DIV) && (i_value_b != '0);
    assign a_neg     = i_signed && i_value_a[WIDTH-1];
    assign b_neg     = i_signed && i_value_b[WIDTH-1];
    assign mag_a     = cond_neg(a_neg, i_value_a);
    assign mag_b     = cond_neg(b_neg, i_value_b);

    // Stage p0: operands and divide sign plan captured at accept
    always_ff @(posedge clk) begin
        if (accept) begin
            a_p0       <= i_value_a;
            b_p0       <= i_value_b;
            op_p0      <= op_e'(i_op);
            sgn_p0     <= i_signed;
            neg_q_p0   <= a_neg ^ b_neg;
            neg_r_p0   <= a_neg;
            ovf_div_p0 <= i_signed && (i_value_a == {1'b1, {(WIDTH-1){1'b0}}}) && (i_value_b == '1);
        end
    end

    // Stage p1: single-cycle datapath evaluated from the captured operands
    assign sum_p1    = {1'b0, a_p0} + {1'b0, b_p0};
    assign diff_p1   = {1'b0, a_p0} - {1'b0, b_p0};
    assign prod_u_p1 = {{WIDTH{1'b0}}, a_p0} * {{WIDTH{1'b0}}, b_p0};
    assign prod_s_p1 = {{WIDTH{a_p0[WIDTH-1]}}, a_p0} * {{WIDTH{b_p0[WIDTH-1]}}, b_p0};
    assign prod_p1   = sgn_p0 ? prod_s_p1 : prod_u_p1;

    seq_divider #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_div (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (div_start),
        .dividend  (mag_a),
        .divisor   (mag_b),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    // Results land on entry to DONE; o_valid follows one edge later and holds until consumed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            o_valid     <= 1'b0;
            o_result    <= '0;
            o_result_hi <= '0;
            o_overflow  <= 1'b0;
            o_div_zero  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) state <= div_start ? S_DIV : S_EXEC;
                end
                S_EXEC: begin
                    state       <= S_DONE;
                    o_result_hi <= '0;
                    o_div_zero  <= 1'b0;
                    case (op_p0)
                        OP_ADD: begin
                            o_result   <= sum_p1[WIDTH-1:0];
                            o_overflow <= add_ovf(sgn_p0, a_p0, b_p0, sum_p1);
                        end
                        OP_SUB: begin
                            o_result   <= diff_p1[WIDTH-1:0];
                            o_overflow <= sub_ovf(sgn_p0, a_p0, b_p0, diff_p1);
                        end
                        OP_MUL: begin
                            o_result    <= prod_p1[WIDTH-1:0];
                            o_result_hi <= prod_p1[2*WIDTH-1:WIDTH];
                            o_overflow  <= mul_ovf(sgn_p0, prod_p1);
                        end
                        OP_DIV: begin
                            o_result    <= '1;
                            o_result_hi <= a_p0;
                            o_overflow  <= 1'b0;
                            o_div_zero  <= 1'b1;
                        end
                    endcase
                end
                S_DIV: begin
                    // MIN / -1 yields MIN naturally after negation; only the flag needs raising.
                    if (div_done) begin
                        state       <= S_DONE;
                        o_result    <= cond_neg(neg_q_p0, div_quo);
                        o_result_hi <= cond_neg(neg_r_p0, div_rem);
                        o_overflow  <= ovf_div_p0;
                        o_div_zero  <= 1'b0;
                    end
                end
                S_DONE: begin
                    if (!o_valid) begin
                        o_valid <= 1'b1;
                    end else if (i_ready) begin
                        o_valid <= 1'b0;
                        state   <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule
